shift_register_arbiter: RTL
===========================

Name: shift_register_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one variable_shift_register delay line among NREQ requesters.
- Selects one requester per cycle and muxes its word into the shared register.
- Drives the register's clock enable.
- Tracks each in-flight word with a tag pipeline, so every word returns to its owner exactly SIZE enabled cycles later.

Parameters:
- WIDTH, 4, data word width; matches the shared register's WIDTH.
- SIZE, 3, depth of the shared register in stages; also the tag pipeline depth; SIZE >= 1.
- NREQ, 4, number of requesters; NREQ >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low; rst=0 at a rising edge resets the block.
- req  input  NREQ  per-requester request; held high with data until granted.
- din  input  NREQ*WIDTH  packed request data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, combinational from req and the priority pointer.
- sr_ce  output  1  clock enable to the shared register.
- sr_din  output  WIDTH  data to the shared register.
- sr_dout  input  WIDTH  data from the shared register.
- rsp_valid  output  NREQ  one-hot: a returned word belongs to requester i.
- rsp_data  output  WIDTH  returned word; equals sr_dout.
- busy  output  1  high while any tag in the pipeline is valid.

Behaviour:
Arbitration
- Round-robin with a log2(NREQ)-bit priority pointer ptr.
- Search starts at index ptr and wraps modulo NREQ; the first requester found with req high gets gnt.
- A transfer occurs on any edge where (req & gnt) != 0.
- On a transfer, ptr <= granted index + 1, wrapping modulo NREQ.
- With no request, ptr holds.
- Reset value: ptr=0, so requester 0 has top priority after reset.

Datapath
- sr_din = din slice of the granted requester.
- sr_din = 0 when no grant.

Tag pipeline
- SIZE stages; each stage holds {valid, id}.
- When sr_ce=1: stage0 <= {transfer, granted id} and stage k <= stage k-1. Idle cycles shift in invalid bubbles.
- When sr_ce=0: all stages hold.
- rsp_valid = onehot(last.id) when last.valid, otherwise 0.
- rsp_data = sr_dout, unregistered pass-through.

Clock-enable gating
- sr_ce = (req != 0) | busy.
- When no request is present and the pipeline is empty, the shared register is frozen.
- Freezing is safe because the register and the tag pipeline always advance together.
- busy = OR of all stage valid bits.

Latency
- A word transferred at edge t appears with rsp_valid at the output after edge t+SIZE-1, i.e. in the SIZE-th cycle after its grant cycle.
- This holds provided sr_ce stays high, which is guaranteed while busy=1.
- Throughput: one word per cycle, sustained.

Reset
- Applies while rst=0 at an edge: all tag valids <= 0, ptr <= 0.
- gnt, sr_ce, rsp_valid and busy are forced to 0 combinationally while rst=0.
- sr_din = 0 while rst=0.
- Stale contents in the shared register are masked by the invalid tags and are never reported.

Boundaries
- Simultaneous grant and response in the same cycle are independent; both proceed.
- Pointer wraps from NREQ-1 to 0.
- A lone requester is granted every cycle.
- A requester dropping req before grant is never granted and nothing is queued.

Test Plan:
- Reset: rst=0 for 3 edges with req=4'hF → gnt=0, sr_ce=0, rsp_valid=0, busy=0. First edge after release grants requester 0.
- Single transfer: req=4'b0100, din slice2=4'ha for one cycle → gnt=4'b0100 and sr_din=4'ha that cycle. Exactly 3 cycles later rsp_valid=4'b0100 and rsp_data=4'ha for one cycle.
- Full contention: req=4'hF held, din slice i = i+1 → grants 0,1,2,3,0,… every cycle. Responses arrive back to back with data 1,2,3,4,1,… after 3 cycles.
- Fairness: req=4'b1001 held → grants alternate 0,3,0,3; neither requester starves.
- CE gating: after the last grant, sr_ce stays 1 for 3 cycles. busy drops together with the final rsp_valid, then sr_ce=0 and tags hold.
- Reset mid-flight: two words in flight, pulse rst=0 for one edge → neither word ever raises rsp_valid, busy=0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/shift_register_arbiter_if.sv
// Bundle between the requesters, the shared delay line and the arbiter.
// The master side owns req/din and the delay-line output; the arbiter is the slave.
interface shift_register_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       gnt;
    logic                  sr_ce;
    logic [WIDTH-1:0]      sr_din;
    logic [WIDTH-1:0]      sr_dout;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  busy;

    modport master (
        output req, din, sr_dout,
        input  gnt, sr_ce, sr_din, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req, din, sr_dout,
        output gnt, sr_ce, sr_din, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/shift_register_arbiter.sv
// Round-robin arbiter sharing one external delay line among NREQ requesters.
// A tag pipeline of the same depth as the delay line remembers the owner of
// each in-flight word so it can be handed back when it falls out the far end.
// Both the delay line and the tags advance only on sr_ce, so they stay aligned
// even while the shared register is frozen.
module shift_register_arbiter #(
    parameter int WIDTH = 4,
    parameter int SIZE  = 3,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_register_arbiter_if.slave bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [SIZE-1:0]  tag_valid_q, tag_valid_d;
    logic [PTR_W-1:0] tag_id_q [SIZE];
    logic [PTR_W-1:0] tag_id_d [SIZE];

    logic [NREQ-1:0]  gnt_c;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_found;
    int               scan_idx;
    logic [WIDTH-1:0] sr_din_c;
    logic             busy_c;
    logic             ce_c;
    logic [NREQ-1:0]  rsp_valid_c;

    // Scan requesters starting at the priority pointer, wrapping modulo NREQ
    always_comb begin
        gnt_c     = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!gnt_found && rst && bus.req[scan_idx]) begin
                gnt_found       = 1'b1;
                gnt_idx         = PTR_W'(scan_idx);
                gnt_c[scan_idx] = 1'b1;
            end
        end
    end

    // Mux the granted requester's word onto the delay line input
    always_comb begin
        sr_din_c = '0;
        if (gnt_found) begin
            sr_din_c = bus.din[int'(gnt_idx)*WIDTH +: WIDTH];
        end
    end

    // Enable the delay line whenever there is new work or words still in flight
    always_comb begin
        busy_c = rst && (|tag_valid_q);
        ce_c   = rst && ((|bus.req) || busy_c);
    end

    // Pointer advance and tag pipeline shift
    always_comb begin
        ptr_d       = ptr_q;
        tag_valid_d = tag_valid_q;
        tag_id_d    = tag_id_q;
        if (gnt_found) begin
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
        if (ce_c) begin
            tag_valid_d[0] = gnt_found;
            tag_id_d[0]    = gnt_idx;
            for (int k = 1; k < SIZE; k++) begin
                tag_valid_d[k] = tag_valid_q[k-1];
                tag_id_d[k]    = tag_id_q[k-1];
            end
        end
    end

    // Pointer and tag valids; reset discards every in-flight word
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q       <= '0;
            tag_valid_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    // Tag ids need no reset; they are only looked at when their valid is set
    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
    end

    // Return the word at the far end to its owner
    always_comb begin
        rsp_valid_c = '0;
        if (rst && tag_valid_q[SIZE-1]) begin
            rsp_valid_c[tag_id_q[SIZE-1]] = 1'b1;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.sr_din    = sr_din_c;
    assign bus.sr_ce     = ce_c;
    assign bus.busy      = busy_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = bus.sr_dout;
endmodule
